// File: rtl/writeback_stage.sv
// ----------------------------------------------------------------------------
// writeback_stage : MEM/WB register, writeback select, 32x32 register file
//                   with WB->ID bypass and retired-instruction counter.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module writeback_stage #(
  parameter int REG_COUNT = 32,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_M,
  input  logic [31:0]      IR_M,
  input  logic [31:0]      ALU_output_M,
  input  logic [31:0]      LMD_M,
  input  logic             stall_W,
  input  logic             flush_W,
  input  logic [4:0]       rs_addr_D,
  input  logic [4:0]       rt_addr_D,
  output logic [31:0]      rs_data_D,
  output logic [31:0]      rt_data_D,
  output logic [31:0]      IR_W,
  output logic             reg_we_W,
  output logic [4:0]       dest_W,
  output logic [31:0]      wb_data_W,
  output logic [CNT_W-1:0] retired_W
);

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LOAD  = 6'b001001;

  logic             valid_q, valid_d;
  logic [31:0]      ir_q, ir_d;
  logic [31:0]      alu_q, alu_d;
  logic [31:0]      lmd_q, lmd_d;
  logic [31:0]      rf_q [REG_COUNT];
  logic [CNT_W-1:0] retired_q;

  logic [5:0]       w_op;
  logic             w_is_rtype;
  logic             w_is_imm;
  logic             w_is_load;
  logic             w_commit;

  always_comb begin
    valid_d = valid_q;
    ir_d    = ir_q;
    alu_d   = alu_q;
    lmd_d   = lmd_q;
    if (flush_W) begin
      valid_d = 1'b0;
      ir_d    = '0;
      alu_d   = '0;
      lmd_d   = '0;
    end else if (!stall_W) begin
      valid_d = valid_M;
      ir_d    = IR_M;
      alu_d   = ALU_output_M;
      lmd_d   = LMD_M;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ir_q    <= '0;
      alu_q   <= '0;
      lmd_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ir_q    <= ir_d;
      alu_q   <= alu_d;
      lmd_q   <= lmd_d;
    end
  end

  assign w_op       = ir_q[31:26];
  assign w_is_rtype = (w_op == c_OP_RTYPE);
  assign w_is_imm   = (w_op[5:2] == 4'b0001);
  assign w_is_load  = (w_op == c_OP_LOAD);

  assign IR_W      = ir_q;
  assign dest_W    = w_is_rtype ? ir_q[15:11] : ir_q[20:16];
  assign wb_data_W = w_is_load ? lmd_q : alu_q;
  assign reg_we_W  = valid_q && (w_is_rtype || w_is_imm || w_is_load) && (dest_W != 5'd0);

  // The instruction in WB commits on any edge that is not stalled; a flush
  // only replaces what enters WB, it does not cancel what is leaving.
  assign w_commit = !stall_W;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        rf_q[i] <= '0;
      end
    end else if (w_commit && reg_we_W) begin
      rf_q[dest_W] <= wb_data_W;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
    end else if (w_commit && valid_q) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign retired_W = retired_q;

  assign rs_data_D = (rs_addr_D == 5'd0)                  ? 32'd0     :
                     (reg_we_W && (rs_addr_D == dest_W))  ? wb_data_W :
                                                            rf_q[rs_addr_D];
  assign rt_data_D = (rt_addr_D == 5'd0)                  ? 32'd0     :
                     (reg_we_W && (rt_addr_D == dest_W))  ? wb_data_W :
                                                            rf_q[rt_addr_D];

endmodule

`default_nettype wire
